// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, controller states and a sizing helper for the flush counter.
package hazard_unit_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Control bits carried by every shadow slot next to its three addresses
    localparam int SLOT_CTRL_W = 3;

    // Branch-flush controller states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Width needed to hold the largest value the flush counter is loaded with
    function automatic int flush_cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/hazard_unit_slot.sv
// One shadow pipeline slot. The valid flag sits in the MSB so that a clear
// can drop the slot without touching its address and control fields.
module hazard_slot
    import hazard_unit_pkg::*;
#(
    parameter int WIDTH = 5 * 3 + SLOT_CTRL_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture the next slot contents; a clear overrides the loaded valid bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            if (load) begin
                q <= d;
            end
            if (clear) begin
                q[WIDTH-1] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: tracks the instructions
// in EX, MEM and WB, resolves load-use stalls, taken-branch flushes and
// selects the EX operand forwarding paths.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int RADDR        = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [RADDR-1:0] rs1_id,
    input  logic [RADDR-1:0] rs2_id,
    input  logic [RADDR-1:0] rd_ex,
    input  logic             we_ex,
    input  logic             memtoreg_ex,
    input  logic             pcsrc_ex,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] rd;
        logic             we;
        logic             memtoreg;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);
    localparam int CNT_W  = flush_cnt_width(FLUSH_CYCLES);

    slot_t            ex_d, mem_d;
    slot_t            ex_q, mem_q, wb_q;
    state_t           state;
    logic [CNT_W-1:0] flush_cnt;
    logic             branch_taken;
    logic             flushing;
    logic             load_use;

    // The EX slot only knows its sources; rd/we/memtoreg arrive on the *_ex
    // ports and are captured as the instruction moves on to MEM.
    assign ex_d  = '{valid: id_valid, rs1: rs1_id, rs2: rs2_id,
                     rd: '0, we: 1'b0, memtoreg: 1'b0};
    assign mem_d = '{valid: ex_q.valid, rs1: ex_q.rs1, rs2: ex_q.rs2,
                     rd: rd_ex, we: we_ex, memtoreg: memtoreg_ex};

    hazard_slot #(.WIDTH(SLOT_W)) u_ex_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (!stall_if_id),
        .clear   (bubble_id_ex),
        .d       (ex_d),
        .q       (ex_q)
    );

    hazard_slot #(.WIDTH(SLOT_W)) u_mem_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (1'b1),
        .clear   (1'b0),
        .d       (mem_d),
        .q       (mem_q)
    );

    hazard_slot #(.WIDTH(SLOT_W)) u_wb_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (1'b1),
        .clear   (1'b0),
        .d       (mem_q),
        .q       (wb_q)
    );

    // Fields kept for slot uniformity that no hazard check ever looks at
    logic unused_fields;
    assign unused_fields = ^{ex_q.rd, ex_q.we, ex_q.memtoreg, mem_q.rs1,
                             mem_q.rs2, wb_q.rs1, wb_q.rs2, wb_q.memtoreg};

    assign branch_taken = (state == ST_IDLE) && ex_q.valid && pcsrc_ex;
    assign flushing     = branch_taken || (state == ST_FLUSH);

    assign load_use = ex_q.valid && we_ex && memtoreg_ex && (rd_ex != '0)
                      && id_valid && ((rd_ex == rs1_id) || (rd_ex == rs2_id));

    // A flush discards the ID instruction anyway, so it wins over a stall
    assign flush_if_id  = flushing;
    assign bubble_id_ex = flushing || load_use;
    assign stall_if_id  = load_use && !flushing;

    // Track the extra flush cycles after the branch cycle; the FLUSH state
    // is left as the counter runs down to zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (branch_taken && (FLUSH_CYCLES > 1)) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt <= CNT_W'(1)) begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    // MEM is checked last so it overrides WB; loads in MEM have no data yet
    function automatic logic [1:0] fwd_select(input logic [RADDR-1:0] src,
                                              input slot_t mem_s,
                                              input slot_t wb_s);
        logic [1:0] sel;
        sel = FWD_REG;
        if (wb_s.valid && wb_s.we && (wb_s.rd != '0) && (wb_s.rd == src)) begin
            sel = FWD_WB;
        end
        if (mem_s.valid && mem_s.we && !mem_s.memtoreg && (mem_s.rd != '0)
            && (mem_s.rd == src)) begin
            sel = FWD_MEM;
        end
        return sel;
    endfunction

    // Operand forwarding for the instruction sitting in EX
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (ex_q.valid) begin
            fwd_a = fwd_select(ex_q.rs1, mem_q, wb_q);
            fwd_b = fwd_select(ex_q.rs2, mem_q, wb_q);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: hand-derived vector table for the directed hazard
// scenarios, a reset-in-flush sequence, and random traffic against a
// pipeline-level reference model.
module tb_hazard_unit;

    localparam int FC = 2;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic       mt;
        logic       pcsrc;
    } stim_t;

    typedef struct {
        stim_t      stim;
        logic [6:0] exp_out;
    } vec_t;

    typedef struct {
        bit valid;
        int rs1;
        int rs2;
        int rd;
        bit we;
        bit mt;
    } instr_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       we_ex, memtoreg_ex, pcsrc_ex;
    logic       stall_if_id, bubble_id_ex, flush_if_id;
    logic [1:0] fwd_a, fwd_b;
    logic [6:0] outs;

    int passed = 0;
    int total  = 0;

    instr_t pipe[3];
    int     flush_left;
    vec_t   vectors[17];

    always #5 clock = ~clock;

    assign outs = {stall_if_id, bubble_id_ex, flush_if_id, fwd_a, fwd_b};

    hazard_unit #(.RADDR(5), .FLUSH_CYCLES(FC)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rd_ex        (rd_ex),
        .we_ex        (we_ex),
        .memtoreg_ex  (memtoreg_ex),
        .pcsrc_ex     (pcsrc_ex),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    function automatic stim_t mk_stim(input int v, input int r1, input int r2,
                                      input int rd, input int we, input int mt,
                                      input int pc);
        stim_t s;
        s.id_valid = 1'(v);
        s.rs1      = 5'(r1);
        s.rs2      = 5'(r2);
        s.rd       = 5'(rd);
        s.we       = 1'(we);
        s.mt       = 1'(mt);
        s.pcsrc    = 1'(pc);
        return s;
    endfunction

    function automatic vec_t mk_vec(input stim_t s, input logic [6:0] e);
        vec_t t;
        t.stim    = s;
        t.exp_out = e;
        return t;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.id_valid = ($urandom_range(0, 3) != 0);
        s.rs1      = 5'($urandom_range(0, 3));
        s.rs2      = 5'($urandom_range(0, 3));
        s.rd       = 5'($urandom_range(0, 3));
        s.we       = 1'($urandom_range(0, 1));
        s.mt       = 1'($urandom_range(0, 1));
        s.pcsrc    = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, and the number
    // of flush cycles still owed after the current one
    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            pipe[i] = '{valid: 1'b0, rs1: 0, rs2: 0, rd: 0, we: 1'b0, mt: 1'b0};
        end
        flush_left = 0;
    endfunction

    function automatic logic [1:0] model_fwd(input int src);
        for (int st = 1; st <= 2; st++) begin
            if (pipe[st].valid && pipe[st].we && pipe[st].rd != 0
                && pipe[st].rd == src && !(st == 1 && pipe[st].mt)) begin
                return (st == 1) ? 2'b10 : 2'b01;
            end
        end
        return 2'b00;
    endfunction

    function automatic bit model_branch(input stim_t s);
        return (flush_left == 0) && pipe[0].valid && (s.pcsrc == 1'b1);
    endfunction

    function automatic logic [6:0] model_outputs(input stim_t s);
        bit flushing, load_use, stall, bubble;
        logic [1:0] fa, fb;
        flushing = model_branch(s) || (flush_left > 0);
        load_use = pipe[0].valid && s.we && s.mt && (s.rd != 0) && s.id_valid
                   && (int'(s.rd) == int'(s.rs1) || int'(s.rd) == int'(s.rs2));
        stall    = load_use && !flushing;
        bubble   = flushing || load_use;
        fa = pipe[0].valid ? model_fwd(pipe[0].rs1) : 2'b00;
        fb = pipe[0].valid ? model_fwd(pipe[0].rs2) : 2'b00;
        return {stall, bubble, flushing, fa, fb};
    endfunction

    function automatic void model_advance(input stim_t s);
        logic [6:0] o;
        bit branch;
        o      = model_outputs(s);
        branch = model_branch(s);
        pipe[2]    = pipe[1];
        pipe[1]    = pipe[0];
        pipe[1].rd = int'(s.rd);
        pipe[1].we = s.we;
        pipe[1].mt = s.mt;
        if (o[6]) begin
            pipe[0].valid = 1'b0;
        end else begin
            pipe[0].valid = s.id_valid && !o[5];
            pipe[0].rs1   = int'(s.rs1);
            pipe[0].rs2   = int'(s.rs2);
        end
        if (branch) flush_left = FC - 1;
        else if (flush_left > 0) flush_left--;
    endfunction

    task automatic applyStimulus(input stim_t s);
        id_valid    = s.id_valid;
        rs1_id      = s.rs1;
        rs2_id      = s.rs2;
        rd_ex       = s.rd;
        we_ex       = s.we;
        memtoreg_ex = s.mt;
        pcsrc_ex    = s.pcsrc;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s[%0d]: stall/bubble/flush/fwd_a/fwd_b got %b required %b",
                     name, idx, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive one cycle, check away from the edge, then step the model
    task automatic run_cycle(input stim_t s, input bit use_model,
                             input logic [6:0] fixed_exp, input string name,
                             input int idx);
        logic [6:0] e;
        applyStimulus(s);
        if (!reset_n) model_reset();
        @(negedge clock);
        e = use_model ? model_outputs(s) : fixed_exp;
        checkOutput(name, idx, outs, e);
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_advance(s);
        #1;
    endtask

    // Test sequence
    initial begin
        vectors[0]  = mk_vec(mk_stim(1, 1, 0,  0, 0, 0, 0), 7'b0000000);
        vectors[1]  = mk_vec(mk_stim(1, 5, 2,  5, 1, 1, 0), 7'b1100000);
        vectors[2]  = mk_vec(mk_stim(1, 5, 2,  0, 0, 0, 0), 7'b0000000);
        vectors[3]  = mk_vec(mk_stim(1, 1, 2,  6, 1, 0, 0), 7'b0000100);
        vectors[4]  = mk_vec(mk_stim(1, 3, 4,  3, 1, 0, 0), 7'b0000000);
        vectors[5]  = mk_vec(mk_stim(1, 9, 10, 8, 1, 0, 0), 7'b0001000);
        vectors[6]  = mk_vec(mk_stim(1, 8, 0, 11, 1, 0, 0), 7'b0000000);
        vectors[7]  = mk_vec(mk_stim(1, 0, 12, 0, 1, 0, 0), 7'b0000100);
        vectors[8]  = mk_vec(mk_stim(1, 1, 1, 13, 1, 0, 0), 7'b0000000);
        vectors[9]  = mk_vec(mk_stim(1, 2, 2,  7, 1, 0, 0), 7'b0000000);
        vectors[10] = mk_vec(mk_stim(1, 4, 7,  7, 1, 0, 0), 7'b0000000);
        vectors[11] = mk_vec(mk_stim(0, 0, 0, 14, 1, 0, 0), 7'b0000010);
        vectors[12] = mk_vec(mk_stim(1, 1, 2,  0, 0, 0, 0), 7'b0000000);
        vectors[13] = mk_vec(mk_stim(1, 5, 0,  5, 1, 1, 1), 7'b0110000);
        vectors[14] = mk_vec(mk_stim(1, 5, 0,  5, 1, 1, 1), 7'b0110000);
        vectors[15] = mk_vec(mk_stim(1, 3, 3,  5, 1, 1, 1), 7'b0000000);
        vectors[16] = mk_vec(mk_stim(0, 0, 0,  0, 0, 0, 0), 7'b0000000);

        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(rand_stim(), 1'b0, 7'b0, "reset_hold", i);
        end
        reset_n = 1'b1;
        run_cycle(rand_stim(), 1'b0, 7'b0, "reset_release", 0);

        reset_n = 1'b0;
        run_cycle(mk_stim(0, 0, 0, 0, 0, 0, 0), 1'b0, 7'b0, "pre_table_reset", 0);
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            run_cycle(vectors[i].stim, 1'b0, vectors[i].exp_out, "table", i);
        end

        run_cycle(mk_stim(1, 1, 2, 0, 0, 0, 0), 1'b0, 7'b0000000, "pre_branch", 0);
        run_cycle(mk_stim(1, 3, 3, 0, 0, 0, 1), 1'b0, 7'b0110000, "branch_first", 0);
        applyStimulus(mk_stim(1, 5, 5, 0, 0, 0, 1));
        @(negedge clock);
        checkOutput("branch_second", 0, outs, 7'b0110000);
        #1 reset_n = 1'b0;
        #1 checkOutput("reset_mid_flush", 0, outs, 7'b0000000);
        model_reset();
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            run_cycle(rand_stim(), 1'b0, 7'b0, "reset_hold2", i);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_cycle(mk_stim(0, 5, 5, 5, 1, 1, 1), 1'b0, 7'b0, "pcsrc_no_valid", i);
        end

        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            run_cycle(rand_stim(), 1'b1, 7'b0, "random", i);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
